// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits, each held for prescale+1 clocks. Frame settings are captured on accept.
module uart_tx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                  state_q;
    logic [PRESCALE_W-1:0]   cnt_q;
    logic [BitW-1:0]         bit_idx_q;
    logic                    stop_idx_q;
    logic [DATA_W-1:0]       data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    stop2_q;
    logic [PRESCALE_W-1:0]   prescale_q;

    logic                    bit_end;
    logic [BitW-1:0]         next_idx;
    logic                    parity_bit;

    always_comb begin
        bit_end    = (cnt_q == '0);
        next_idx   = bit_idx_q + 1'b1;
        parity_bit = (^data_q) ^ par_typ_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            prescale_q <= '0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (Data_Valid) begin
                        data_q     <= P_DATA;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        stop2_q    <= STOP2;
                        prescale_q <= prescale;
                        cnt_q      <= prescale;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        state_q    <= StStart;
                        TX_OUT     <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                StStart: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q     <= prescale_q;
                        bit_idx_q <= '0;
                        TX_OUT    <= data_q[0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q <= prescale_q;
                        if (bit_idx_q == LastBit) begin
                            bit_idx_q <= '0;
                            if (par_en_q) begin
                                TX_OUT  <= parity_bit;
                                state_q <= StParity;
                            end else begin
                                TX_OUT     <= 1'b1;
                                stop_idx_q <= 1'b0;
                                state_q    <= StStop;
                            end
                        end else begin
                            bit_idx_q <= next_idx;
                            TX_OUT    <= data_q[next_idx];
                        end
                    end
                end
                StParity: begin
                    if (!bit_end) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q      <= prescale_q;
                        TX_OUT     <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= StStop;
                    end
                end
                StStop: begin
                    TX_OUT <= 1'b1;
                    if (!bit_end) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (stop2_q && !stop_idx_q) begin
                        cnt_q      <= prescale_q;
                        stop_idx_q <= 1'b1;
                    end else begin
                        // Frame complete: pulse done and free the transmitter in the same edge.
                        cnt_q      <= '0;
                        stop_idx_q <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cnt_q      <= '0;
                    bit_idx_q  <= '0;
                    stop_idx_q <= 1'b0;
                    TX_OUT     <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: expected line levels are queued per cycle when a
// frame is requested and compared cycle by cycle while busy is high.
module tb_uart_tx_param;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 8;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [DATA_W-1:0]     P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] prescale;
    logic                  TX_OUT;
    logic                  busy;
    logic                  frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic exp_q[$];
    int   len_q[$];

    uart_tx_param #(
        .DATA_W    (DATA_W),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .prescale  (prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge; returns one negedge later, when the start bit should be on the line.
    task automatic send(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                        input logic s2, input logic [PRESCALE_W-1:0] ps);
        logic bits[$];
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        prescale   = ps;
        Data_Valid = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (int'(ps) + 1) exp_q.push_back(bits[i]);
        len_q.push_back(bits.size() * (int'(ps) + 1));
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    // Returns at the negedge of the frame_done cycle.
    task automatic check_frame(input string name);
        int   len;
        int   cnt;
        logic e;
        len = len_q.pop_front();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s start: busy=%b want 1", name, busy);
            repeat (len) if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < len + 10) begin
            e = (cnt < len && exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            n_cmp++;
            if (TX_OUT !== e) begin
                n_err++;
                $display("FAIL %s bit cycle %0d: TX_OUT=%b want %b", name, cnt, TX_OUT, e);
            end
            n_cmp++;
            if (frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s done-while-busy cycle %0d: frame_done=%b want 0",
                         name, cnt, frame_done);
            end
            cnt++;
            @(negedge CLK);
        end
        while (cnt < len && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            cnt++;
        end
        n_cmp++;
        if (cnt != len) begin
            n_err++;
            $display("FAIL %s busy length: got %0d want %0d", name, cnt, len);
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s frame_done: got %b want 1", name, frame_done);
        end
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s end idle: TX_OUT=%b busy=%b want 1 0", name, TX_OUT, busy);
        end
    endtask

    task automatic check_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s idle cycle %0d: TX_OUT=%b busy=%b done=%b want 1 0 0",
                         name, i, TX_OUT, busy, frame_done);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        Data_Valid = 1'b0;
        P_DATA = '0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STOP2 = 1'b0;
        prescale = '0;
        #12;
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: TX_OUT=%b busy=%b done=%b want 1 0 0",
                     TX_OUT, busy, frame_done);
        end
        @(negedge CLK);
        RST = 1'b1;
        check_idle(2, "post_reset");
    endtask

    task automatic test_basic();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0);
        check_frame("basic_a5");
        check_idle(3, "basic_a5");
    endtask

    task automatic test_parity();
        send(8'hA5, 1'b1, 1'b0, 1'b0, 8'd0);
        check_frame("parity_even");
        check_idle(2, "parity_even");
        send(8'hA5, 1'b1, 1'b1, 1'b0, 8'd0);
        check_frame("parity_odd");
        check_idle(2, "parity_odd");
    endtask

    task automatic test_prescale();
        send(8'h01, 1'b1, 1'b0, 1'b1, 8'd3);
        check_frame("presc3_stop2");
        check_idle(2, "presc3_stop2");
    endtask

    task automatic test_mid_frame_inputs();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1);
        fork
            check_frame("mid_frame");
            begin
                repeat (5) @(negedge CLK);
                P_DATA     = 8'hFF;
                prescale   = 8'd7;
                PAR_EN     = 1'b1;
                STOP2      = 1'b1;
                Data_Valid = 1'b1;
                @(negedge CLK);
                Data_Valid = 1'b0;
            end
        join
        check_idle(6, "mid_frame");
    endtask

    task automatic test_reset_mid_frame();
        send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0);
        // Now in the start-bit cycle; data bit 3 is four cycles later and drives 0.
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid pre: TX_OUT=%b busy=%b want 0 1", TX_OUT, busy);
        end
        #1 RST = 1'b0;
        #1;
        n_cmp++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid async: TX_OUT=%b busy=%b done=%b want 1 0 0",
                     TX_OUT, busy, frame_done);
        end
        exp_q.delete();
        len_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        check_idle(2, "rst_mid");
        send(8'h3C, 1'b0, 1'b0, 1'b0, 8'd0);
        check_frame("after_rst_3c");
        check_idle(2, "after_rst_3c");
    endtask

    task automatic test_back_to_back();
        send(8'h55, 1'b0, 1'b0, 1'b0, 8'd0);
        check_frame("b2b_55");
        send(8'hAA, 1'b0, 1'b0, 1'b0, 8'd0);
        check_frame("b2b_aa");
        check_idle(2, "b2b_aa");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_prescale();
        test_mid_frame_inputs();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that generates a complete serial frame: start bit, DATA_W data bits sent LSB first, optional even/odd parity, and one or two stop bits. It contains an internal per-bit prescaler and a frame FSM, with registered serial output and status. It sits between the system-side parallel data source and the TX pin. It replaces the fixed 8-bit, one-stop-bit, one-clock-per-bit transmit path.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 8, width of the prescale input.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous active-low reset.
P_DATA  in  DATA_W  parallel data word to transmit.
Data_Valid  in  1  request to transmit P_DATA; accepted only while busy=0.
PAR_EN  in  1  1 = append a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
STOP2  in  1  0 = one stop bit, 1 = two stop bits.
prescale  in  PRESCALE_W  bit period = prescale+1 CLK cycles.
TX_OUT  out  1  serial line, registered; idle level 1.
busy  out  1  registered; high for the whole frame.
frame_done  out  1  registered one-cycle pulse after the final stop bit.

Behaviour:
- Reset (RST=0, asynchronous): TX_OUT=1, busy=0, frame_done=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; the line returns to 1 with no partial stop bit.
- Acceptance: in IDLE, Data_Valid=1 on a rising edge captures P_DATA, PAR_EN, PAR_TYP, STOP2 and prescale into shadow registers. Input changes after capture have no effect on the frame in progress.
- Data_Valid while busy=1 is ignored. There is no queueing.
- Latency: acceptance at edge k gives TX_OUT=0 and busy=1 from edge k+1.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
- Bit timing: each bit, including every stop bit, holds TX_OUT for exactly prescale+1 cycles. A down-counter is reloaded at each bit start. prescale=0 gives one cycle per bit.
- DATA state: bit counter runs 0..DATA_W-1. TX_OUT = shadow data[bit index], LSB first.
- PARITY state: TX_OUT = (XOR of all data bits) XOR PAR_TYP. Even parity makes the total number of ones in data+parity even.
- STOP state: TX_OUT=1 for 1 or 2 bit periods, per the captured STOP2.
- Frame length: (1 + DATA_W + PAR_EN + 1 + STOP2) * (prescale+1) cycles. busy is high for exactly this many cycles.
- End of frame: on the edge after the last stop-bit cycle, busy=0 and frame_done=1 for one cycle. TX_OUT stays 1.
- Back-to-back frames: Data_Valid in the same cycle that frame_done=1 is accepted. The next start bit begins one cycle later, so the minimum idle gap between frames is 1 cycle at TX_OUT=1.
- Illegal or unused FSM encodings recover to IDLE with TX_OUT=1 and busy=0.
- Counter widths: prescale counter PRESCALE_W bits; bit counter $clog2(DATA_W) bits; stop counter 1 bit. No counter may wrap outside its defined range.

Test Plan:
- DATA_W=8, prescale=0, PAR_EN=0, STOP2=0, P_DATA=0xA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; busy high for 10 cycles; frame_done pulses once on cycle 11.
- Same data with PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; busy high 11 cycles in each case.
- prescale=3, P_DATA=0x01, PAR_EN=1, PAR_TYP=0, STOP2=1 -> every bit held 4 cycles; parity bit 1; two stop bits; busy high exactly 48 cycles.
- Pulse Data_Valid with P_DATA=0xFF mid-frame, and change prescale and PAR_EN mid-frame -> current frame is unaltered and 0xFF is never sent.
- Assert RST=0 during data bit 3 -> TX_OUT=1 and busy=0 asynchronously. After release, a new 0x3C frame transmits correctly from its start bit.
- Data_Valid asserted in the frame_done cycle with 0x55 then 0xAA -> exactly one idle cycle at TX_OUT=1 between frames, and both frames are bit-correct.
